// File: rtl/mult_err_sampler.sv
// mult_err_sampler
//   Run controller for an approximate-vs-exact 32x32 signed multiplier pair.
//   It accepts a batch of operand pairs on a valid/ready stream and drives
//   them back-to-back onto an operand bus shared by both multipliers. LAT
//   edges after each issue it retires both 64-bit products and accumulates
//   the absolute error. It then presents the batch statistics on a held
//   valid/ready result port.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, n_samples      batch start pulse (honoured in IDLE) and batch length
//   busy                  high while a batch is running, draining or reporting
//   in_valid/in_ready     operand stream handshake; in_a/in_b signed operands
//   mul_a, mul_b          registered operands to both multipliers
//   y_appx, y_exact       signed products returned by the multipliers
//   st_valid/st_ready     statistics handshake; st_valid holds until accepted
//   st_sum                saturating sum of |y_exact - y_appx|
//   st_max                largest |error| in the batch
//   st_nerr               number of samples with a nonzero error
//   st_cnt                number of samples retired
module mult_err_sampler #(
  parameter int unsigned LAT   = 3,
  parameter int unsigned ACC_W = 80,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [63:0]      y_appx,
  input  logic [63:0]      y_exact,
  output logic             st_valid,
  input  logic             st_ready,
  output logic [ACC_W-1:0] st_sum,
  output logic [63:0]      st_max,
  output logic [CNT_W-1:0] st_nerr,
  output logic [CNT_W-1:0] st_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] issued;
  logic [LAT-1:0]   vpipe;

  logic             xfer;
  logic             retire;
  logic             last_issue;
  logic             last_retire;
  logic             accept_start;

  logic [64:0]      diff;
  logic [64:0]      diff_abs;
  logic [63:0]      err;
  logic [ACC_W:0]   sum_ext;

  // Issue / retire bookkeeping
  assign accept_start = (state == S_IDLE) && start;
  assign xfer         = in_valid && in_ready;
  assign retire       = vpipe[LAT-1];
  assign last_issue   = xfer && ((issued + CNT_W'(1)) == n_lat);
  // The last retire is recognised by count so the pipe need not be inspected.
  assign last_retire  = retire && ((st_cnt + CNT_W'(1)) == n_lat);

  // Error of the sample being retired, in 65-bit signed arithmetic so the
  // full range of the difference of two 64-bit signed values is exact.
  always_comb begin
    diff     = {y_exact[63], y_exact} - {y_appx[63], y_appx};
    diff_abs = diff[64] ? (65'd0 - diff) : diff;
    err      = diff_abs[64] ? '1 : diff_abs[63:0];
    sum_ext  = {1'b0, st_sum} + (ACC_W + 1)'(err);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    in_ready = 1'b0;
    st_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (n_samples == '0) ? S_REPORT : S_RUN;
        end
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = (issued < n_lat);
        if (last_issue) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (last_retire) begin
          state_nx = S_REPORT;
        end
      end
      S_REPORT: begin
        busy     = 1'b1;
        st_valid = 1'b1;
        if (st_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand bus, issue counter and valid pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat  <= '0;
      issued <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      vpipe  <= '0;
    end else begin
      // Shift every cycle; a bubble enters whenever no pair is transferred.
      vpipe <= (vpipe << 1) | LAT'(xfer);
      if (accept_start) begin
        n_lat  <= n_samples;
        issued <= '0;
      end else if (xfer) begin
        issued <= issued + CNT_W'(1);
      end
      if (xfer) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
    end
  end

  // Statistics accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_sum  <= '0;
      st_max  <= '0;
      st_nerr <= '0;
      st_cnt  <= '0;
    end else if (accept_start) begin
      st_sum  <= '0;
      st_max  <= '0;
      st_nerr <= '0;
      st_cnt  <= '0;
    end else if (retire) begin
      st_sum  <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if (err > st_max) begin
        st_max <= err;
      end
      if (err != '0) begin
        st_nerr <= st_nerr + CNT_W'(1);
      end
      st_cnt <= st_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mult_err_sampler.sv
// tb_mult_err_sampler
//   Directed bench for mult_err_sampler. A stub multiplier pair delays the
//   operand bus by LAT-1 registers and looks up both products in small tables
//   indexed by the low bits of the delayed operand A, so each batch can be
//   given hand-picked errors.
module tb_mult_err_sampler;

  localparam int unsigned LAT   = 3;
  localparam int unsigned ACC_W = 64;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_samples;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [63:0]      y_appx;
  logic [63:0]      y_exact;
  logic             st_valid;
  logic             st_ready;
  logic [ACC_W-1:0] st_sum;
  logic [63:0]      st_max;
  logic [CNT_W-1:0] st_nerr;
  logic [CNT_W-1:0] st_cnt;

  int errors = 0;
  int checks = 0;

  logic [63:0] ye_tab [16];
  logic [63:0] ya_tab [16];
  logic [31:0] a_d1, a_d2;

  always #5 clk = ~clk;

  mult_err_sampler #(
    .LAT   (LAT),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_samples (n_samples),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .y_appx    (y_appx),
    .y_exact   (y_exact),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_sum    (st_sum),
    .st_max    (st_max),
    .st_nerr   (st_nerr),
    .st_cnt    (st_cnt)
  );

  // Stub multipliers: LAT-1 register stages, then a table lookup.
  always_ff @(posedge clk) begin
    a_d1 <= mul_a;
    a_d2 <= a_d1;
  end

  always_comb begin
    y_exact = ye_tab[a_d2[3:0]];
    y_appx  = ya_tab[a_d2[3:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < 16; i++) begin
      ye_tab[i] = '0;
      ya_tab[i] = '0;
    end
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start     = 1'b1;
    n_samples = n;
    tick();
    start     = 1'b0;
  endtask

  // Present one pair and hold it until the edge that accepts it.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        tick();
        done = 1'b1;
        break;
      end
      tick();
    end
    chk("send_accepted", 64'(done), 64'd1);
  endtask

  task automatic wait_report();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (st_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("report_reached", 64'(seen), 64'd1);
  endtask

  task automatic accept_report();
    st_ready = 1'b1;
    tick();
    st_ready = 1'b0;
    chk("st_valid_dropped", 64'(st_valid), 64'd0);
    chk("idle_not_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    n_samples = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    st_ready  = 1'b0;
    clear_tabs();

    // Reset state
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_st_valid", 64'(st_valid), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_st_cnt", 64'(st_cnt), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: no errors, four back-to-back pairs
    do_start(16'd4);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      send(32'(i), 32'hF000_0000 | 32'(i));
    end
    in_valid = 1'b0;
    chk("t1_ready_low_after_4", 64'(in_ready), 64'd0);
    chk("t1_mul_a", 64'(mul_a), 64'd3);
    chk("t1_mul_b", 64'(mul_b), 64'hF000_0003);
    wait_report();
    chk("t1_sum", st_sum, 64'd0);
    chk("t1_max", st_max, 64'd0);
    chk("t1_nerr", 64'(st_nerr), 64'd0);
    chk("t1_cnt", 64'(st_cnt), 64'd4);
    accept_report();

    // 2: errors +5 then -3
    ye_tab[0] = 64'd10;  ya_tab[0] = 64'd5;
    ye_tab[1] = 64'd0;   ya_tab[1] = 64'd3;
    do_start(16'd2);
    send(32'd0, 32'd7);
    send(32'd1, 32'd7);
    in_valid = 1'b0;
    wait_report();
    chk("t2_sum", st_sum, 64'd8);
    chk("t2_max", st_max, 64'd5);
    chk("t2_nerr", 64'(st_nerr), 64'd2);
    chk("t2_cnt", 64'(st_cnt), 64'd2);
    accept_report();

    // 3: full-range error then 1, sum saturates
    ye_tab[0] = 64'h7FFF_FFFF_FFFF_FFFF; ya_tab[0] = 64'h8000_0000_0000_0000;
    ye_tab[1] = 64'd1;                   ya_tab[1] = 64'd0;
    do_start(16'd2);
    send(32'd0, 32'd0);
    send(32'd1, 32'd0);
    in_valid = 1'b0;
    wait_report();
    chk("t3_max", st_max, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_sum", st_sum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_nerr", 64'(st_nerr), 64'd2);
    chk("t3_cnt", 64'(st_cnt), 64'd2);
    accept_report();

    // 4: gapped input, stray starts, held report
    clear_tabs();
    ye_tab[0] = 64'd100; ya_tab[0] = 64'd99;
    ye_tab[1] = 64'd100; ya_tab[1] = 64'd98;
    ye_tab[2] = 64'd100; ya_tab[2] = 64'd100;
    ye_tab[3] = 64'd100; ya_tab[3] = 64'd107;
    do_start(16'd4);
    for (int i = 0; i < 4; i++) begin
      send(32'(i), 32'd1);
      in_valid = 1'b0;
      start    = (i == 1);
      n_samples = 16'd9;
      tick();
      start    = 1'b0;
    end
    wait_report();
    for (int j = 0; j < 10; j++) begin
      start     = (j == 3);
      n_samples = '0;
      tick();
      chk("t4_st_valid_held", 64'(st_valid), 64'd1);
      chk("t4_in_ready_low", 64'(in_ready), 64'd0);
      chk("t4_sum_stable", st_sum, 64'd10);
    end
    start = 1'b0;
    chk("t4_max", st_max, 64'd7);
    chk("t4_nerr", 64'(st_nerr), 64'd3);
    chk("t4_cnt", 64'(st_cnt), 64'd4);
    accept_report();

    // 5: empty batch reports zeros on the next cycle
    do_start(16'd0);
    chk("t5_st_valid", 64'(st_valid), 64'd1);
    chk("t5_sum", st_sum, 64'd0);
    chk("t5_max", st_max, 64'd0);
    chk("t5_nerr", 64'(st_nerr), 64'd0);
    chk("t5_cnt", 64'(st_cnt), 64'd0);
    chk("t5_mul_a_kept", 64'(mul_a), 64'd3);
    accept_report();

    // 6: reset mid-batch, then a clean batch
    clear_tabs();
    do_start(16'd8);
    send(32'd1, 32'd11);
    send(32'd2, 32'd12);
    send(32'd3, 32'd13);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t6_rst_st_valid", 64'(st_valid), 64'd0);
    chk("t6_rst_mul_a", 64'(mul_a), 64'd0);
    chk("t6_rst_mul_b", 64'(mul_b), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    ye_tab[4] = 64'd50; ya_tab[4] = 64'd40;
    do_start(16'd2);
    send(32'd4, 32'd0);
    send(32'd5, 32'd0);
    in_valid = 1'b0;
    wait_report();
    chk("t6_cnt", 64'(st_cnt), 64'd2);
    chk("t6_nerr", 64'(st_nerr), 64'd1);
    chk("t6_sum", st_sum, 64'd10);
    chk("t6_max", st_max, 64'd10);
    accept_report();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
